uart_alu_interface: RTL

- Command/response engine on the far side of the UART link; it consumes bytes delivered by the UART receiver and drives the UART transmitter.
- Collects a three-byte command (operand A, operand B, opcode), presents it to a combinational ALU, then returns the single-byte result over TX.
- Sits between the uart block (rx_done/rx data in, tx_start/tx data out) and the ALU.

---
 rtl/uart_alu_interface.sv | 110 +++++++++++
 1 files changed

// File: rtl/uart_alu_interface.sv
`timescale 1ns/1ps
// Three-byte UART command collector (A, B, opcode) feeding a combinational ALU, returning one result byte over TX.
// Optional inter-byte timeout under UART_ALU_INTERFACE_TIMEOUT_EN; tx_start fires 2 cycles after the opcode byte.
module uart_alu_interface #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int NB_STATE       = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done_tick,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_timeout
);

    typedef enum logic [NB_STATE-1:0] {
        IDLE_A  = NB_STATE'(0),
        WAIT_B  = NB_STATE'(1),
        WAIT_OP = NB_STATE'(2),
        EXEC    = NB_STATE'(3),
        SEND    = NB_STATE'(4),
        WAIT_TX = NB_STATE'(5)
    } state_t;

    state_t state;
    state_t state_next;
    logic   timeout_hit;

`ifdef UART_ALU_INTERFACE_TIMEOUT_EN
    localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [NB_CNT-1:0] cnt;
    logic              waiting;

    assign waiting     = (state == WAIT_B) || (state == WAIT_OP);
    // A byte arriving on the terminal count cycle takes priority over the abort.
    assign timeout_hit = waiting && (cnt == NB_CNT'(TIMEOUT_CYCLES - 1)) && !i_rx_done_tick;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (!waiting || i_rx_done_tick || timeout_hit) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign o_timeout  = timeout_hit;
    assign o_tx_start = (state == SEND);
    assign o_busy     = (state != IDLE_A);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE_A:  if (i_rx_done_tick) state_next = WAIT_B;
            WAIT_B: begin
                if (i_rx_done_tick)   state_next = WAIT_OP;
                else if (timeout_hit) state_next = IDLE_A;
            end
            WAIT_OP: begin
                if (i_rx_done_tick)   state_next = EXEC;
                else if (timeout_hit) state_next = IDLE_A;
            end
            EXEC:    state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: if (i_tx_done_tick) state_next = IDLE_A;
            default: state_next = IDLE_A;
        endcase
    end

    // Operand and result registers only change on their own capture event, so they persist between commands.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
        end else begin
            case (state)
                IDLE_A:  if (i_rx_done_tick) o_alu_a  <= i_rx_data;
                WAIT_B:  if (i_rx_done_tick) o_alu_b  <= i_rx_data;
                WAIT_OP: if (i_rx_done_tick) o_alu_op <= i_rx_data[NB_OP-1:0];
                EXEC:    o_tx_data <= i_alu_result;
                default: ;
            endcase
        end
    end

endmodule
